// File: rtl/csa_accum_sequencer.sv
// csa_accum_sequencer: carry-save multi-operand accumulator with a final carry-propagate resolve
module csa_accum_sequencer #(
  parameter int WIDTH = 16,
  parameter int OPS_W = 3,
  localparam int ACC_W = WIDTH + OPS_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OPS_W:0]   num_ops,
  input  logic             op_valid,
  input  logic [WIDTH-1:0] op_data,
  output logic             op_ready,
  output logic             busy,
  output logic             res_valid,
  output logic [ACC_W-1:0] res_data,
  input  logic             res_ready
);
  typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;
  localparam logic [OPS_W:0] MAX_N = {1'b1, {OPS_W{1'b0}}};
  state_t state, state_nx;
  logic [ACC_W-1:0] s, c, x;
  logic [OPS_W:0] cnt, n, n_clamp;
  logic beat, last;
  assign n_clamp = num_ops > MAX_N ? MAX_N : num_ops;
  assign x = {{OPS_W{1'b0}}, op_data};
  assign beat = state == ACCUM && op_valid;
  assign last = beat && cnt + 1'b1 == n;
  assign op_ready = state == ACCUM;
  assign busy = state != IDLE;
  assign res_valid = state == DONE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? (n_clamp == '0 ? DONE : ACCUM) : IDLE;
      ACCUM:   state_nx = last ? RESOLVE : ACCUM;
      RESOLVE: state_nx = DONE;
      DONE:    state_nx = res_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      s <= '0;
      c <= '0;
      cnt <= '0;
      n <= '0;
      res_data <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        s <= '0;
        c <= '0;
        cnt <= '0;
        n <= n_clamp;
        if (n_clamp == '0) res_data <= '0;
      end
      if (beat) begin
        s <= s ^ c ^ x;
        c <= ((s & c) | (s & x) | (c & x)) << 1;
        cnt <= cnt + 1'b1;
      end
      if (state == RESOLVE) res_data <= s + c;
    end
  end
endmodule

// File: tb/tb_csa_accum_sequencer.sv
// tb_csa_accum_sequencer: randomized scoreboard bench against a plain-sum reference model
module tb_csa_accum_sequencer;
  localparam int WIDTH = 16, OPS_W = 3, ACC_W = WIDTH + OPS_W, MAXN = 8;
  typedef logic [WIDTH-1:0] data_q_t[$];
  logic clk = 0, rst, start, op_valid, op_ready, busy, res_valid, res_ready;
  logic [OPS_W:0] num_ops;
  logic [WIDTH-1:0] op_data;
  logic [ACC_W-1:0] res_data, prev_data;
  logic [ACC_W-1:0] exp_q[$];
  int checks = 0, errors = 0, accepts = 0;
  bit rr_rand = 0, prev_stall = 0;

  csa_accum_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .num_ops(num_ops), .op_valid(op_valid),
    .op_data(op_data), .op_ready(op_ready), .busy(busy), .res_valid(res_valid),
    .res_data(res_data), .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: count accepted beats, check result hold under stall, pop scoreboard on handshake
  always @(negedge clk) begin
    if (rst) prev_stall = 0;
    else begin
      if (op_valid && op_ready) accepts++;
      if (prev_stall) begin
        check("hold_valid", res_valid, 1);
        check("hold_data", res_data, prev_data);
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) check("spurious_result", res_valid, 0);
        else check("res_data", res_data, exp_q.pop_front());
      end
      prev_stall = res_valid && !res_ready;
      prev_data = res_data;
    end
  end

  always @(posedge clk) if (rr_rand) begin
    #1 res_ready = $urandom_range(0, 2) != 0;
  end

  task automatic do_reset();
    rst = 1;
    start = 0;
    op_valid = 0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_op_ready", op_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    exp_q.delete();
    rst = 0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 300) begin
      tick();
      t++;
    end
    check("idle_timeout", busy, 0);
  endtask

  task automatic run_job(input int n, input data_q_t ops, input int gap_pct);
    int eff = n > MAXN ? MAXN : n;
    int i = 0, t = 0, a0;
    logic [ACC_W-1:0] sum = 0;
    for (int k = 0; k < eff; k++) sum += ACC_W'(ops[k]);
    wait_idle();
    exp_q.push_back(sum);
    a0 = accepts;
    start = 1;
    num_ops = n[OPS_W:0];
    tick();
    start = 0;
    while (i < eff && t < 500) begin
      op_valid = $urandom_range(0, 99) >= gap_pct;
      op_data = op_valid ? ops[i] : WIDTH'($urandom);
      @(negedge clk);
      if (op_valid && op_ready) i++;
      tick();
      t++;
    end
    check("beat_timeout", i, eff);
    // extra offered beats after the job is full must be refused
    op_valid = 1;
    op_data = WIDTH'($urandom);
    if (eff > 0) check("lat_resolve", res_valid, 0);
    tick();
    if (eff > 0) check("lat_done", res_valid, 1);
    tick();
    tick();
    op_valid = 0;
    check("accept_count", accepts - a0, eff);
  endtask

  initial begin
    data_q_t q;
    rst = 1;
    start = 0;
    num_ops = 0;
    op_valid = 0;
    op_data = 0;
    res_ready = 1;
    do_reset();
    q = {16'hFFFF, 16'hFFFF, 16'hFFFF};
    run_job(3, q, 0);
    q = {16'hB3CB, 16'h5555, 16'hEF0C};
    run_job(3, q, 0);
    q.delete();
    repeat (8) q.push_back(16'hFFFF);
    run_job(8, q, 40);
    // n==0 with stalled consumer; start pulses in DONE must be ignored
    wait_idle();
    res_ready = 0;
    exp_q.push_back(0);
    start = 1;
    num_ops = 0;
    tick();
    start = 0;
    check("n0_valid", res_valid, 1);
    repeat (3) begin
      start = 1;
      num_ops = 4;
      tick();
      check("n0_stall_valid", res_valid, 1);
      check("n0_stall_data", res_data, 0);
      check("n0_stall_busy", busy, 1);
    end
    res_ready = 1;
    tick();
    start = 0;
    check("n0_idle", busy, 0);
    tick();
    check("n0_start_ignored", busy, 0);
    q.delete();
    repeat (10) q.push_back(WIDTH'($urandom));
    run_job(15, q, 20);
    // reset while parked in DONE
    wait_idle();
    res_ready = 0;
    start = 1;
    num_ops = 0;
    tick();
    start = 0;
    do_reset();
    res_ready = 1;
    // reset mid-ACCUM after two beats, then a fresh single-beat job
    start = 1;
    num_ops = 4;
    tick();
    start = 0;
    op_valid = 1;
    op_data = 16'hABCD;
    tick();
    op_data = 16'h1234;
    tick();
    op_valid = 0;
    check("abort_busy", busy, 1);
    do_reset();
    q = {16'h0001};
    run_job(1, q, 0);
    rr_rand = 1;
    repeat (12) begin
      q.delete();
      repeat (16) q.push_back(WIDTH'($urandom));
      run_job($urandom_range(0, 15), q, 30);
    end
    rr_rand = 0;
    @(posedge clk);
    #2 res_ready = 1;
    wait_idle();
    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end
endmodule
